// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the hex keypad front end:
//   - scan_state_t : scanner FSM states
//   - COL_RESET    : column drive after reset (column 0 driven low)
//   - ROWS_IDLE    : synchronised row pattern with no key down
//   - encode_key() : key index (row*4+col) -> emitted byte
//   - lowest_row() : index of the lowest low row in an active-low pattern
// Configuration macro: KEYPAD_ASCII_EN
//   defined   -> keys 0-9 emit 8'h30-8'h39, keys 10-15 emit 8'h41-8'h46
//   undefined -> keys emit {4'h0, index}
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;
    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic logic [7:0] encode_key(input logic [3:0] idx);
        logic [7:0] code;
`ifdef KEYPAD_ASCII_EN
        if (idx < 4'd10) begin
            code = 8'h30 + {4'h0, idx};
        end else begin
            code = 8'h41 + {4'h0, idx - 4'd10};
        end
`else
        code = {4'h0, idx};
`endif
        return code;
    endfunction

    // Several rows low at once: the lowest row index wins.
    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0]) begin
            r = 2'd0;
        end else if (!rows[1]) begin
            r = 2'd1;
        end else if (!rows[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// -----------------------------------------------------------------------------
// key_fifo
// Small synchronous FIFO holding encoded key bytes.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : store push_data (dropped with overflow set when full,
//                  unless a pop happens in the same cycle)
//   push_data    : byte to store
//   pop          : discard head entry (ignored when empty)
//   head_data    : head entry, 0 when empty
//   full, empty  : occupancy flags
//   overflow     : sticky, set when a push was dropped; cleared by reset only
// -----------------------------------------------------------------------------
module key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == COUNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full queue
    // still lands and occupancy stays put.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// 4x4 hex keypad front end: column scan, row synchronisation, debounce,
// key encoding and a small key queue feeding a byte/ready consumer port.
// Parameters:
//   SCAN_DIV   : clocks per column; rows are judged on the last one (>=4)
//   DEBOUNCE   : consecutive stable ticks to accept a press/release (>=1)
//   FIFO_DEPTH : queued keys, power of two, >=2
// Ports:
//   CLK         : clock, rising edge
//   nCLR        : asynchronous active-low reset
//   row_in      : keypad rows, active-low, asynchronous
//   col_out     : column drive, active-low, one-hot low
//   acknowledge : consumer handshake; each rising edge pops one key
//   Keyboard    : head key code, 8'h00 when empty
//   ready       : queue non-empty
//   overflow    : sticky, a key was dropped on a full queue
// Configuration macro: KEYPAD_ASCII_EN (ASCII key codes instead of raw index)
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 16,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic [3:0] row_in,
    input  logic       acknowledge,
    output logic [3:0] col_out,
    output logic [7:0] Keyboard,
    output logic       ready,
    output logic       overflow
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LIM  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       row_p0;
    logic [3:0]       row_p1;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    scan_state_t      state;
    logic [1:0]       col_idx;
    logic [3:0]       pattern;
    logic [CNT_W-1:0] stable_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             rows_idle;
    logic             vld_p2;
    logic [7:0]       code_p2;
    logic             ack_q;
    logic             pop_p;
    logic             fifo_empty;

    // ---- stage p0/p1: row synchroniser --------------------------------------
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            row_p0 <= ROWS_IDLE;
            row_p1 <= ROWS_IDLE;
        end else begin
            row_p0 <= row_in;
            row_p1 <= row_p0;
        end
    end

    // Column dwell divider; rows are judged once per column on the tick.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick      = (div_cnt == DIV_LAST);
    assign rows_idle = (row_p1 == ROWS_IDLE);
    assign cnt_next  = stable_cnt + 1'b1;

    // ---- stage p2: scanner FSM and push request -----------------------------
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state      <= ST_SCAN;
            col_out    <= COL_RESET;
            col_idx    <= 2'd0;
            stable_cnt <= '0;
            vld_p2     <= 1'b0;
        end else begin
            vld_p2 <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (rows_idle) begin
                            col_idx <= col_idx + 1'b1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end else begin
                            stable_cnt <= CNT_ONE;
                            if (CNT_ONE == DEB_LIM) begin
                                vld_p2 <= 1'b1;
                                state  <= ST_HOLD;
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        // An all-high pattern never equals the latched one,
                        // so release is covered by the mismatch branch.
                        if (row_p1 == pattern) begin
                            stable_cnt <= cnt_next;
                            if (cnt_next == DEB_LIM) begin
                                vld_p2 <= 1'b1;
                                state  <= ST_HOLD;
                            end
                        end else begin
                            state   <= ST_SCAN;
                            col_idx <= col_idx + 1'b1;
                            col_out <= {col_out[2:0], col_out[3]};
                        end
                    end
                    ST_HOLD: begin
                        if (rows_idle) begin
                            stable_cnt <= CNT_ONE;
                            state      <= (CNT_ONE == DEB_LIM) ? ST_SCAN : ST_RELEASE;
                        end
                    end
                    ST_RELEASE: begin
                        if (rows_idle) begin
                            stable_cnt <= cnt_next;
                            if (cnt_next == DEB_LIM) state <= ST_SCAN;
                        end else begin
                            state <= ST_HOLD;
                        end
                    end
                endcase
            end
        end
    end

    // Data path: latched pattern and the encoded key travelling with vld_p2.
    // code_p2 tracks the live key every cycle; it is only consumed when
    // vld_p2 is set, which happens on the same edge it was captured.
    always_ff @(posedge CLK) begin
        if (tick && state == ST_SCAN && !rows_idle) pattern <= row_p1;
        code_p2 <= encode_key({lowest_row(row_p1), col_idx});
    end

    // Acknowledge edge detect; the pop is registered so it lands one edge
    // after the rising edge is sampled.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            ack_q <= 1'b0;
            pop_p <= 1'b0;
        end else begin
            ack_q <= acknowledge;
            pop_p <= acknowledge && !ack_q;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (nCLR),
        .push      (vld_p2),
        .push_data (code_p2),
        .pop       (pop_p),
        .head_data (Keyboard),
        .full      (),
        .empty     (fifo_empty),
        .overflow  (overflow)
    );

    assign ready = !fifo_empty;

endmodule
